// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register word map, FSEL field geometry and sizing helper
// shared by the GPIO bank RTL. GPIO_DEBOUNCE_EN selects the debounced input path.
package gpio_bank_pkg;

  localparam int FSEL_W             = 4;
  localparam int FSEL_SIO           = 0;
  localparam int PINS_PER_FSEL_WORD = 8;

  // APB word index (paddr[6:2]); FSEL words start at R_FSEL0
  typedef enum logic [4:0] {
    R_OUT       = 5'h00,
    R_OUT_XOR   = 5'h01,
    R_OUT_SET   = 5'h02,
    R_OUT_CLR   = 5'h03,
    R_OE        = 5'h04,
    R_OE_XOR    = 5'h05,
    R_OE_SET    = 5'h06,
    R_OE_CLR    = 5'h07,
    R_IN        = 5'h08,
    R_INTR_RISE = 5'h09,
    R_INTR_FALL = 5'h0A,
    R_INTE_RISE = 5'h0B,
    R_INTE_FALL = 5'h0C,
    R_INTE_HIGH = 5'h0D,
    R_INTE_LOW  = 5'h0E,
    R_INTS      = 5'h0F,
    R_FSEL0     = 5'h10
  } reg_e;

  function automatic int fsel_words(input int n);
    return (n + PINS_PER_FSEL_WORD - 1) / PINS_PER_FSEL_WORD;
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// gpio_bank_if: APB slave bundle for the GPIO bank.
interface gpio_bank_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
endinterface

// File: rtl/gpio_bank_in_filter.sv
// gpio_in_filter: one pin's input path. Two-flop synchroniser, plus a
// stable-count debouncer when GPIO_DEBOUNCE_EN is defined.
module gpio_in_filter #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic q
);
  logic s1, s2;

  // metastability guard for the asynchronous pad
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pad;
      s2 <= s1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [15:0] cnt;

  // accept a new level only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (s2 != q) begin
      if (cnt == 16'(DB_CYCLES - 1)) begin
        q   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  logic unused_db;
  assign unused_db = ^DB_CYCLES;
  assign q = s2;
`endif

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: APB GPIO bank with alias OUT/OE updates, per-pin function mux,
// synchronised inputs and edge/level interrupts. Optional GPIO_DEBOUNCE_EN.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int N_GPIO    = 8,
  parameter int N_FUNC    = 3,
  parameter int DB_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  gpio_bank_if.slave               apbs,
  input  logic [N_FUNC*N_GPIO-1:0] alt_out,
  input  logic [N_FUNC*N_GPIO-1:0] alt_oe,
  output logic [N_GPIO-1:0]        in_sync,
  output logic                     irq,
  output logic [N_GPIO-1:0]        padout_gpio,
  output logic [N_GPIO-1:0]        padoe_gpio,
  input  logic [N_GPIO-1:0]        padin_gpio
);
  localparam int NW = fsel_words(N_GPIO);

  logic [N_GPIO-1:0] out_r, oe_r, intr_rise, intr_fall;
  logic [N_GPIO-1:0] inte_rise, inte_fall, inte_high, inte_low;
  logic [N_GPIO-1:0] prev, rise, fall, ints, wdat, w1c_rise, w1c_fall;
  logic [N_GPIO-1:0][FSEL_W-1:0] fsel;
  logic [4:0]  idx;
  logic        mapped, wr;
  logic [31:0] rdata;
  logic        unused_bits;

  assign idx     = apbs.paddr[6:2];
  assign mapped  = (apbs.paddr[15:7] == 9'd0) && (!idx[4] || int'(idx[3:0]) < NW);
  assign wr      = apbs.psel & apbs.penable & apbs.pwrite & mapped;
  assign wdat    = apbs.pwdata[N_GPIO-1:0];
  assign unused_bits = ^{apbs.paddr[1:0], apbs.pwdata};

  assign apbs.pready  = 1'b1;
  assign apbs.pslverr = apbs.psel & apbs.penable & ~mapped;
  assign apbs.prdata  = (apbs.psel && mapped) ? rdata : 32'd0;

  gpio_in_filter #(.DB_CYCLES(DB_CYCLES)) u_filt [N_GPIO-1:0] (
    .clk (clk),
    .rst (rst),
    .pad (padin_gpio),
    .q   (in_sync)
  );

  assign rise     = in_sync & ~prev;
  assign fall     = ~in_sync & prev;
  assign ints     = (intr_rise & inte_rise) | (intr_fall & inte_fall) |
                    (in_sync & inte_high) | (~in_sync & inte_low);
  assign w1c_rise = (wr && idx == R_INTR_RISE) ? wdat : '0;
  assign w1c_fall = (wr && idx == R_INTR_FALL) ? wdat : '0;

  // read mux; aliases return the base register, FSEL packs 8 pins per word
  always_comb begin
    rdata = '0;
    case (idx)
      R_OUT, R_OUT_XOR, R_OUT_SET, R_OUT_CLR: rdata = 32'(out_r);
      R_OE, R_OE_XOR, R_OE_SET, R_OE_CLR:     rdata = 32'(oe_r);
      R_IN:        rdata = 32'(in_sync);
      R_INTR_RISE: rdata = 32'(intr_rise);
      R_INTR_FALL: rdata = 32'(intr_fall);
      R_INTE_RISE: rdata = 32'(inte_rise);
      R_INTE_FALL: rdata = 32'(inte_fall);
      R_INTE_HIGH: rdata = 32'(inte_high);
      R_INTE_LOW:  rdata = 32'(inte_low);
      R_INTS:      rdata = 32'(ints);
      default:
        for (int g = 0; g < N_GPIO; g++)
          if (idx[4] && (g / PINS_PER_FSEL_WORD) == int'(idx[3:0]))
            rdata[(g % PINS_PER_FSEL_WORD)*FSEL_W +: FSEL_W] = fsel[g];
    endcase
  end

  // software-writable registers, updated in the APB access phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r     <= '0;
      oe_r      <= '0;
      inte_rise <= '0;
      inte_fall <= '0;
      inte_high <= '0;
      inte_low  <= '0;
      fsel      <= '0;
    end else if (wr) begin
      case (idx)
        R_OUT:       out_r     <= wdat;
        R_OUT_XOR:   out_r     <= out_r ^ wdat;
        R_OUT_SET:   out_r     <= out_r | wdat;
        R_OUT_CLR:   out_r     <= out_r & ~wdat;
        R_OE:        oe_r      <= wdat;
        R_OE_XOR:    oe_r      <= oe_r ^ wdat;
        R_OE_SET:    oe_r      <= oe_r | wdat;
        R_OE_CLR:    oe_r      <= oe_r & ~wdat;
        R_INTE_RISE: inte_rise <= wdat;
        R_INTE_FALL: inte_fall <= wdat;
        R_INTE_HIGH: inte_high <= wdat;
        R_INTE_LOW:  inte_low  <= wdat;
        default:
          for (int g = 0; g < N_GPIO; g++)
            if (idx[4] && (g / PINS_PER_FSEL_WORD) == int'(idx[3:0]))
              fsel[g] <= apbs.pwdata[(g % PINS_PER_FSEL_WORD)*FSEL_W +: FSEL_W];
      endcase
    end
  end

  // sticky edge status; a fresh edge beats a simultaneous W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      intr_rise <= '0;
      intr_fall <= '0;
      irq       <= 1'b0;
    end else begin
      prev      <= in_sync;
      intr_rise <= (intr_rise & ~w1c_rise) | rise;
      intr_fall <= (intr_fall & ~w1c_fall) | fall;
      irq       <= |ints;
    end
  end

  // per-pin mux; unused selector slots stay 0 so FSEL > N_FUNC parks the pad
  for (genvar g = 0; g < N_GPIO; g++) begin : g_pin
    logic [15:0] fo, fe;

    // gather SIO and alternate-function sources for this pin
    always_comb begin
      fo = '0;
      fe = '0;
      fo[FSEL_SIO] = out_r[g];
      fe[FSEL_SIO] = oe_r[g];
      for (int f = 1; f <= N_FUNC; f++) begin
        fo[f] = alt_out[(f-1)*N_GPIO + g];
        fe[f] = alt_oe[(f-1)*N_GPIO + g];
      end
    end

    assign padout_gpio[g] = fo[fsel[g]];
    assign padoe_gpio[g]  = fe[fsel[g]];
  end

endmodule
